fpu_req_arbiter: RTL and testbench

// - Shares one fpu instance between two requesters (e.g. two CPU-side ports).
// - Per-port valid/ready request and response handshakes; round-robin grant.
// - The fpu has no start/done: this block restarts it by pulsing its active-low reset.
//   It then holds the operands stable for FPU_LATENCY cycles, samples data_out/status_out
//   and returns them to the granted requester.

---
 rtl/fpu_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// Round-robin share of one reset-started fpu between two valid/ready requesters.
// Result returns FPU_LATENCY+1 cycles after accept; a stalled response blocks new grants.
module fpu_req_arbiter #(
  parameter int FPU_LATENCY = 6,
  parameter int CNT_W       = 4
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_op_a,
  input  logic [63:0] req_op_b,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_status,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  output logic        fpu_rst_n,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state, w_state;
  logic        r_last_grant, w_last_grant;
  logic        r_owner, w_owner;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]  r_resp_valid, w_resp_valid;
  logic [31:0] r_resp_data, w_resp_data;
  logic [3:0]  r_resp_status, w_resp_status;
  logic [31:0] r_op_a, w_op_a;
  logic [31:0] r_op_b, w_op_b;
  logic        r_fpu_rst_n, w_fpu_rst_n;

  logic        w_grant;
  logic [1:0]  w_req_ready;
  logic        w_hs;

  // With both ports asking, the one not served last time wins.
  assign w_grant     = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_req_ready = ((r_state == S_IDLE) && (req_valid != 2'b00)) ?
                       {w_grant, ~w_grant} : 2'b00;
  assign w_hs        = |(req_valid & w_req_ready);

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_last_grant  = r_last_grant;
    w_owner       = r_owner;
    w_cnt         = r_cnt;
    w_resp_valid  = r_resp_valid;
    w_resp_data   = r_resp_data;
    w_resp_status = r_resp_status;
    w_op_a        = r_op_a;
    w_op_b        = r_op_b;
    w_fpu_rst_n   = r_fpu_rst_n;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_op_a       = w_grant ? req_op_a[63:32] : req_op_a[31:0];
          w_op_b       = w_grant ? req_op_b[63:32] : req_op_b[31:0];
          w_owner      = w_grant;
          w_last_grant = w_grant;
          w_fpu_rst_n  = 1'b0;
          w_state      = S_LAUNCH;
        end else begin
          w_fpu_rst_n  = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_fpu_rst_n = 1'b1;
        w_cnt       = '0;
        w_state     = S_WAIT;
      end
      S_WAIT: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(FPU_LATENCY - 1)) begin
          w_resp_data   = fpu_data;
          w_resp_status = fpu_status;
          w_resp_valid  = {r_owner, ~r_owner};
          w_state       = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready[r_owner]) begin
          w_resp_valid = 2'b00;
          w_state      = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_resp_valid  <= 2'b00;
      r_resp_data   <= '0;
      r_resp_status <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_fpu_rst_n   <= 1'b0;
    end else begin
      r_last_grant  <= w_last_grant;
      r_owner       <= w_owner;
      r_cnt         <= w_cnt;
      r_resp_valid  <= w_resp_valid;
      r_resp_data   <= w_resp_data;
      r_resp_status <= w_resp_status;
      r_op_a        <= w_op_a;
      r_op_b        <= w_op_b;
      r_fpu_rst_n   <= w_fpu_rst_n;
    end
  end

  assign req_ready   = w_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_status = r_resp_status;
  assign fpu_op_a    = r_op_a;
  assign fpu_op_b    = r_op_b;
  assign fpu_rst_n   = r_fpu_rst_n;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: latency-6 and latency-1 instances, each driving an fpu stub.
module tb_fpu_req_arbiter;
  localparam int L = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] req_op_a, req_op_b;
  logic [31:0] resp_data, fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  resp_status, fpu_status;
  logic        fpu_rst_n, busy;

  logic [1:0]  s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [63:0] s_req_op_a, s_req_op_b;
  logic [31:0] s_resp_data, s_fpu_op_a, s_fpu_op_b, s_fpu_data;
  logic [3:0]  s_resp_status, s_fpu_status;
  logic        s_fpu_rst_n, s_busy;

  fpu_req_arbiter #(.FPU_LATENCY(L), .CNT_W(4)) dut (
    .clock100KHz(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_status(resp_status),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_rst_n(fpu_rst_n),
    .fpu_data(fpu_data), .fpu_status(fpu_status), .busy(busy)
  );

  fpu_req_arbiter #(.FPU_LATENCY(1), .CNT_W(4)) dut1 (
    .clock100KHz(clk), .reset(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_op_a(s_req_op_a), .req_op_b(s_req_op_b),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
    .resp_data(s_resp_data), .resp_status(s_resp_status),
    .fpu_op_a(s_fpu_op_a), .fpu_op_b(s_fpu_op_b), .fpu_rst_n(s_fpu_rst_n),
    .fpu_data(s_fpu_data), .fpu_status(s_fpu_status), .busy(s_busy)
  );

  // fpu stubs: result is valid only once the latency has elapsed since reset release
  int st_cnt = 0, st1_cnt = 0;
  always @(posedge clk) begin
    if (!fpu_rst_n) st_cnt <= 0; else if (st_cnt < 100) st_cnt <= st_cnt + 1;
    if (!s_fpu_rst_n) st1_cnt <= 0; else if (st1_cnt < 100) st1_cnt <= st1_cnt + 1;
  end
  assign fpu_data     = (fpu_rst_n && st_cnt >= L - 1) ? (fpu_op_a ^ fpu_op_b) : 32'hDEAD_BEEF;
  assign fpu_status   = (fpu_rst_n && st_cnt >= L - 1) ? 4'd1 : 4'hF;
  assign s_fpu_data   = (s_fpu_rst_n && st1_cnt >= 0) ? (s_fpu_op_a ^ s_fpu_op_b) : 32'hDEAD_BEEF;
  assign s_fpu_status = (s_fpu_rst_n && st1_cnt >= 0) ? 4'd1 : 4'hF;

  int passed = 0, total = 0, fails = 0;
  int m_last;
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 2'b00);
    chk({tag, "_resp_data"}, resp_data, 32'h0);
    chk({tag, "_resp_status"}, resp_status, 4'h0);
    chk({tag, "_ops"}, {fpu_op_a, fpu_op_b}, 64'h0);
    chk({tag, "_fpu_rst_n"}, fpu_rst_n, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
  endtask

  // One full transaction on the latency-6 instance, called at a negedge.
  task automatic do_op(input logic [1:0] v, input int hold, output int og);
    int g, lat;
    logic [31:0] ea, eb;
    g  = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
    og = g;
    ea = pa[g];
    eb = pb[g];
    req_valid  = v;
    req_op_a   = {pa[1], pa[0]};
    req_op_b   = {pb[1], pb[0]};
    resp_ready = 2'b00;
    #1;
    chk("grant_ready", req_ready, oh(g));
    @(posedge clk);
    m_last = g;
    @(negedge clk);
    lat = 0;
    chk("launch_rst_low", fpu_rst_n, 1'b0);
    chk("launch_ops", {fpu_op_a, fpu_op_b}, {ea, eb});
    req_valid[g] = 1'b0;
    pa[g] = $urandom;
    pb[g] = $urandom;
    while (resp_valid == 2'b00 && lat < 60) begin
      chk("wait_no_ready", req_ready, 2'b00);
      @(negedge clk);
      lat++;
      if (lat == 1) chk("fpu_rst_release", fpu_rst_n, 1'b1);
    end
    chk("latency", 64'(lat), 64'(L + 1));
    chk("resp_valid", resp_valid, oh(g));
    chk("resp_data", resp_data, ea ^ eb);
    chk("resp_status", resp_status, 4'd1);
    chk("ops_held", {fpu_op_a, fpu_op_b}, {ea, eb});
    last_data = resp_data;
    for (int i = 0; i < hold; i++) begin
      resp_ready = (g == 1) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("hold_valid", resp_valid, oh(g));
      chk("hold_data", resp_data, ea ^ eb);
      chk("hold_no_ready", req_ready, 2'b00);
    end
    resp_ready = oh(g);
    #1;
    chk("no_same_cycle_accept", req_ready, 2'b00);
    @(negedge clk);
    resp_ready = 2'b00;
    chk("resp_cleared", resp_valid, 2'b00);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, lat, low, stale;
    req_valid = 2'b00; resp_ready = 2'b00; req_op_a = '0; req_op_b = '0;
    s_req_valid = 2'b00; s_resp_ready = 2'b00; s_req_op_a = '0; s_req_op_b = '0;
    m_last = 1;
    pa[0] = $urandom; pa[1] = $urandom; pb[0] = $urandom; pb[1] = $urandom;

    // reset values and first IDLE cycle
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("first_idle_rst_low", fpu_rst_n, 1'b0);
    @(negedge clk);
    chk("idle_rst_high", fpu_rst_n, 1'b1);

    // single request on port 0
    pa[0] = 32'h4000_0000; pb[0] = 32'h0000_0001;
    do_op(2'b01, 0, g);
    chk("single_port", 64'(g), 64'd0);
    chk("single_data", last_data, 32'h4000_0001);

    // both ports valid from reset: 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      do_op(2'b11, 0, g);
      chk("rr_order", 64'(g), 64'(k % 2));
    end

    // port 0 response stalled 20 cycles while port 1 waits
    do_op(2'b11, 20, g);
    chk("stall_owner", 64'(g), 64'd0);
    do_op(2'b11, 0, g);
    chk("after_stall_port1", 64'(g), 64'd1);

    // randomized traffic checked against the grant/result model
    for (int k = 0; k < 25; k++) begin
      do_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), g);
    end

    // reset while waiting with counter at 3
    req_valid = 2'b01;
    req_op_a = {pa[1], pa[0]};
    req_op_b = {pb[1], pb[0]};
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst_next");
    rst_n = 1'b1;
    m_last = 1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) stale++;
    end
    chk("no_stale_resp", 64'(stale), 64'd0);
    do_op(2'b01, 1, g);
    chk("post_reset_port", 64'(g), 64'd0);

    // latency-1 instance
    s_req_op_a = {32'h1234_5678, 32'h0};
    s_req_op_b = {32'h0F0F_0F0F, 32'h0};
    s_req_valid = 2'b10;
    #1;
    chk("l1_ready", s_req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    s_req_valid = 2'b00;
    lat = 0;
    low = 0;
    while (s_resp_valid == 2'b00 && lat < 20) begin
      if (!s_fpu_rst_n) low++;
      @(negedge clk);
      lat++;
    end
    chk("l1_latency", 64'(lat), 64'd2);
    chk("l1_rst_low_cycles", 64'(low), 64'd1);
    chk("l1_resp_valid", s_resp_valid, 2'b10);
    chk("l1_resp_data", s_resp_data, 32'h1234_5678 ^ 32'h0F0F_0F0F);
    chk("l1_resp_status", s_resp_status, 4'd1);
    s_resp_ready = 2'b10;
    @(negedge clk);
    s_resp_ready = 2'b00;
    chk("l1_resp_cleared", s_resp_valid, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
